// File: rtl/icache_pkg.sv
// Shared definitions for the N-way wide instruction cache.
// Geometry helpers and FSM state encoding.
package icache_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RESP = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sets_f(
    input int cs,
    input int nw,
    input int nb,
    input int bs
  );
    return cs / (nw * nb * bs);
  endfunction

  function automatic int tag_bits_f(
    input int cs,
    input int nw,
    input int nb,
    input int bs
  );
    return 30 - clog2_f(nb) - clog2_f(sets_f(cs, nw, nb, bs));
  endfunction

endpackage

// File: rtl/icache_way_array.sv
// One cache way: per-set valid bit, tag and full data line.
// Asynchronous read by set, synchronous line write and clear-all.
module icache_way_array #(
  parameter int SETS     = 16,
  parameter int SW       = 4,
  parameter int TAG_BITS = 24,
  parameter int LW       = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SW-1:0]       rd_set_i,
  output logic                rd_valid_o,
  output logic [TAG_BITS-1:0] rd_tag_o,
  output logic [LW-1:0]       rd_line_o,
  input  logic                wr_en_i,
  input  logic [SW-1:0]       wr_set_i,
  input  logic [TAG_BITS-1:0] wr_tag_i,
  input  logic [LW-1:0]       wr_line_i,
  input  logic                clr_all_i
);

  logic [SETS-1:0]     valid_q;
  logic [TAG_BITS-1:0] tag_q  [SETS];
  logic [LW-1:0]       data_q [SETS];

  // Valid bits: cleared by reset or flush, set by a line fill.
  always_ff @(posedge clk) begin
    if (reset || clr_all_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_set_i] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until valid.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_set_i]  <= wr_tag_i;
      data_q[wr_set_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_set_i];
  assign rd_tag_o   = tag_q[rd_set_i];
  assign rd_line_o  = data_q[rd_set_i];

endmodule

// File: rtl/icache_nwa_wide.sv
// N-way set-associative read-only icache with wide line fill,
// round-robin replacement, critical-word forward and deferred flush.
module icache_nwa_wide
  import icache_pkg::*;
#(
  parameter int CACHE_SIZE = 1024,
  parameter int NUM_WAYS   = 2,
  parameter int NUM_BLOCKS = 4,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    proc_valid,
  output logic                    proc_ready,
  input  logic [31:0]             proc_addr,
  output logic [31:0]             proc_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [31:0]             mem_req_addr,
  input  logic [32*NUM_BLOCKS-1:0] mem_req_rdata,
  input  logic                    flush,
  output logic                    flush_done,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic [31:0]             occupancy
);

  localparam int SETS = sets_f(CACHE_SIZE, NUM_WAYS, NUM_BLOCKS, BLOCK_SIZE);
  localparam int OFF_BITS = clog2_f(NUM_BLOCKS);
  localparam int SET_BITS = clog2_f(SETS);
  localparam int TAG_BITS = tag_bits_f(CACHE_SIZE, NUM_WAYS, NUM_BLOCKS, BLOCK_SIZE);
  localparam int SW = (SET_BITS > 0) ? SET_BITS : 1;
  localparam int WB = (NUM_WAYS > 1) ? clog2_f(NUM_WAYS) : 1;
  localparam int LW = 32 * NUM_BLOCKS;
  localparam logic [31:0] LINE_MASK = ~(32'(NUM_BLOCKS * BLOCK_SIZE) - 32'd1);
  localparam logic [WB-1:0] RR_MASK = WB'(NUM_WAYS - 1);

  state_e        state_q;
  logic [29:0]   addr_q;
  logic          proc_ready_q;
  logic [31:0]   proc_rdata_q;
  logic          mem_req_valid_q;
  logic [31:0]   mem_req_addr_q;
  logic          flush_pend_q;
  logic          flush_done_q;
  logic [31:0]   hit_count_q;
  logic [31:0]   miss_count_q;
  logic [31:0]   occupancy_q;
  logic [WB-1:0] rr_q [SETS];

  logic [29:0]         cur_wa;
  logic [OFF_BITS-1:0] cur_off;
  logic [TAG_BITS-1:0] cur_tag;
  logic [SW-1:0]       cur_set;

  logic [NUM_WAYS-1:0] way_valid;
  logic [NUM_WAYS-1:0] way_hit;
  logic [NUM_WAYS-1:0] way_wr;
  logic [TAG_BITS-1:0] way_tag  [NUM_WAYS];
  logic [LW-1:0]       way_line [NUM_WAYS];

  logic          hit;
  logic [31:0]   hit_word;
  logic [31:0]   crit_word;
  logic          inv_any;
  logic [WB-1:0] inv_idx;
  logic [WB-1:0] victim;
  logic [WB-1:0] rr_next;
  logic          fill_fire;
  logic          flush_apply;

  // The live request address in IDLE, the latched miss address otherwise.
  assign cur_wa  = (state_q == S_IDLE) ? proc_addr[31:2] : addr_q;
  assign cur_off = cur_wa[OFF_BITS-1:0];
  assign cur_tag = cur_wa[29 -: TAG_BITS];

  generate
    if (SET_BITS > 0) begin : g_set
      assign cur_set = cur_wa[OFF_BITS +: SET_BITS];
    end else begin : g_noset
      assign cur_set = '0;
    end
  endgenerate

  generate
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      icache_way_array #(
        .SETS     (SETS),
        .SW       (SW),
        .TAG_BITS (TAG_BITS),
        .LW       (LW)
      ) u_way (
        .clk        (clk),
        .reset      (reset),
        .rd_set_i   (cur_set),
        .rd_valid_o (way_valid[w]),
        .rd_tag_o   (way_tag[w]),
        .rd_line_o  (way_line[w]),
        .wr_en_i    (way_wr[w]),
        .wr_set_i   (cur_set),
        .wr_tag_i   (cur_tag),
        .wr_line_i  (mem_req_rdata),
        .clr_all_i  (flush_apply)
      );
      assign way_hit[w] = way_valid[w] && (way_tag[w] == cur_tag);
      assign way_wr[w]  = fill_fire && (victim == WB'(w));
    end
  endgenerate

  assign fill_fire   = (state_q == S_FILL) && mem_req_ready;
  assign flush_apply = (state_q == S_IDLE) && (flush_pend_q || flush);
  assign crit_word   = mem_req_rdata[32*int'(cur_off) +: 32];
  assign victim      = inv_any ? inv_idx : rr_q[cur_set];
  assign rr_next     = (rr_q[cur_set] + WB'(1)) & RR_MASK;

  // Tag compare, hit word select and lowest-invalid-way search.
  always_comb begin
    hit      = |way_hit;
    hit_word = '0;
    inv_any  = 1'b0;
    inv_idx  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_hit[w]) hit_word = hit_word | way_line[w][32*int'(cur_off) +: 32];
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        inv_any = 1'b1;
        inv_idx = WB'(w);
      end
    end
  end

  // Control FSM with registered outputs, counters and rr pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      proc_ready_q    <= 1'b0;
      mem_req_valid_q <= 1'b0;
      flush_pend_q    <= 1'b0;
      flush_done_q    <= 1'b0;
      hit_count_q     <= '0;
      miss_count_q    <= '0;
      occupancy_q     <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      proc_ready_q <= 1'b0;
      flush_done_q <= 1'b0;
      if (flush) flush_pend_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (flush_apply) begin
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b1;
            occupancy_q  <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
          end else if (proc_valid) begin
            if (hit) begin
              proc_ready_q <= 1'b1;
              proc_rdata_q <= hit_word;
              hit_count_q  <= hit_count_q + 32'd1;
              state_q      <= S_GAP;
            end else begin
              addr_q          <= proc_addr[31:2];
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= proc_addr & LINE_MASK;
              miss_count_q    <= miss_count_q + 32'd1;
              state_q         <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            proc_ready_q    <= 1'b1;
            proc_rdata_q    <= crit_word;
            if (inv_any) occupancy_q <= occupancy_q + 32'd1;
            else rr_q[cur_set] <= rr_next;
            state_q <= S_GAP;
          end
        end
        S_GAP:  state_q <= S_IDLE;
        S_RESP: state_q <= S_IDLE;
      endcase
    end
  end

  assign proc_ready    = proc_ready_q;
  assign proc_rdata    = proc_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign flush_done    = flush_done_q;
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;
  assign occupancy     = occupancy_q;

endmodule

// File: tb/tb_icache_nwa_wide.sv
// Bench for icache_nwa_wide: 2 ways, 16 sets, 4-word lines.
// Expected fetch words queued on request, popped on proc_ready.
module tb_icache_nwa_wide;

  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            proc_valid;
  logic            proc_ready;
  logic [31:0]     proc_addr;
  logic [31:0]     proc_rdata;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [31:0]     mem_req_addr;
  logic [32*NB-1:0] mem_req_rdata;
  logic            flush;
  logic            flush_done;
  logic [31:0]     hit_count;
  logic [31:0]     miss_count;
  logic [31:0]     occupancy;

  int n_pass = 0;
  int n_total = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  int mem_delay = 3;
  logic [31:0] exp_q [$];

  icache_nwa_wide #(
    .CACHE_SIZE (512),
    .NUM_WAYS   (2),
    .NUM_BLOCKS (NB),
    .BLOCK_SIZE (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .proc_valid    (proc_valid),
    .proc_ready    (proc_ready),
    .proc_addr     (proc_addr),
    .proc_rdata    (proc_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_rdata (mem_req_rdata),
    .flush         (flush),
    .flush_done    (flush_done),
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  // Backing memory: word at 0x100 is 0xA0, each next word +1.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + ((a >> 2) - 32'h40);
  endfunction

  function automatic logic [32*NB-1:0] mem_line(input logic [31:0] base);
    logic [32*NB-1:0] l;
    for (int k = 0; k < NB; k++) l[32*k +: 32] = mem_word(base + 32'(4*k));
    return l;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    proc_valid = 1'b0;
    proc_addr = '0;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_req_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    exp_q.delete();
  endtask

  // One fetch through to proc_ready, acting as the fill memory.
  task automatic do_fetch(input logic [31:0] a, input bit exp_miss,
                          input int flush_at);
    int cyc;
    int wcnt;
    int lat;
    bit done;
    bit saw_req;
    logic [31:0] exp;
    cyc = 0;
    wcnt = 0;
    done = 1'b0;
    saw_req = 1'b0;
    exp_q.push_back(mem_word(a));
    if (exp_miss) exp_misses++;
    else exp_hits++;
    proc_addr = a;
    proc_valid = 1'b1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      mem_req_ready = 1'b0;
      flush = (cyc == flush_at);
      if (proc_ready) begin
        done = 1'b1;
        proc_valid = 1'b0;
        exp = exp_q.pop_front();
        n_total++;
        if (proc_rdata !== exp)
          $display("FAIL rdata @%h: got %h want %h", a, proc_rdata, exp);
        else n_pass++;
        lat = exp_miss ? mem_delay + 1 : 1;
        n_total++;
        if (cyc != lat)
          $display("FAIL latency @%h: got %0d want %0d", a, cyc, lat);
        else n_pass++;
      end else if (mem_req_valid) begin
        if (!saw_req) begin
          saw_req = 1'b1;
          n_total++;
          if (mem_req_addr !== (a & 32'hFFFF_FFF0))
            $display("FAIL mem_addr @%h: got %h want %h", a, mem_req_addr,
                     a & 32'hFFFF_FFF0);
          else n_pass++;
        end
        wcnt++;
        if (wcnt == mem_delay) begin
          mem_req_ready = 1'b1;
          mem_req_rdata = mem_line(mem_req_addr);
        end
      end
    end
    flush = 1'b0;
    mem_req_ready = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL timeout @%h: got no proc_ready want one", a);
      proc_valid = 1'b0;
    end
    n_total++;
    if (saw_req !== exp_miss)
      $display("FAIL miss @%h: got %0d want %0d", a, saw_req, exp_miss);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({proc_ready, mem_req_valid, flush_done} !== 3'b000)
      $display("FAIL reset_ctl: got %b want 000",
               {proc_ready, mem_req_valid, flush_done});
    else n_pass++;
    n_total++;
    if ({hit_count, miss_count, occupancy} !== 96'd0)
      $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0",
               hit_count, miss_count, occupancy);
    else n_pass++;
  endtask

  task automatic test_cold_miss();
    do_fetch(32'h100, 1'b1, 0);
    n_total++;
    if (miss_count !== 32'd1 || occupancy !== 32'd1)
      $display("FAIL cold_cnt: got miss %0d occ %0d want 1 1",
               miss_count, occupancy);
    else n_pass++;
    do_fetch(32'h10C, 1'b0, 0);
    n_total++;
    if (hit_count !== 32'd1)
      $display("FAIL hit_cnt: got %0d want 1", hit_count);
    else n_pass++;
  endtask

  task automatic test_evict();
    do_reset();
    do_fetch(32'h000, 1'b1, 0);
    do_fetch(32'h400, 1'b1, 0);
    do_fetch(32'h800, 1'b1, 0);
    n_total++;
    if (occupancy !== 32'd2)
      $display("FAIL evict_occ: got %0d want 2", occupancy);
    else n_pass++;
    do_fetch(32'h400, 1'b0, 0);
    do_fetch(32'h000, 1'b1, 0);
    n_total++;
    if (occupancy !== 32'd2 || miss_count !== 32'(exp_misses)
        || hit_count !== 32'(exp_hits))
      $display("FAIL evict_cnt: got occ %0d miss %0d hit %0d want 2 %0d %0d",
               occupancy, miss_count, hit_count, exp_misses, exp_hits);
    else n_pass++;
  endtask

  task automatic test_flush();
    bit seen;
    do_fetch(32'h200, 1'b1, 2);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (flush_done) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL flush_done: got none want pulse");
    else n_pass++;
    n_total++;
    if (occupancy !== 32'd0)
      $display("FAIL flush_occ: got %0d want 0", occupancy);
    else n_pass++;
    do_fetch(32'h200, 1'b1, 0);
    n_total++;
    if (occupancy !== 32'd1)
      $display("FAIL refill_occ: got %0d want 1", occupancy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exp;
    int idx;
    int cyc;
    int readies;
    bit saw_req;
    addrs[0] = 32'h200;
    addrs[1] = 32'h204;
    addrs[2] = 32'h208;
    addrs[3] = 32'h20C;
    idx = 0;
    cyc = 0;
    readies = 0;
    saw_req = 1'b0;
    proc_addr = addrs[0];
    exp_q.push_back(mem_word(addrs[0]));
    proc_valid = 1'b1;
    while (cyc < 40 && idx < 4) begin
      @(negedge clk);
      cyc++;
      if (mem_req_valid) saw_req = 1'b1;
      if (proc_ready) begin
        readies++;
        exp = exp_q.pop_front();
        n_total++;
        if (proc_rdata !== exp)
          $display("FAIL b2b_rdata %0d: got %h want %h", idx, proc_rdata, exp);
        else n_pass++;
        idx++;
        exp_hits++;
        if (idx < 4) begin
          proc_addr = addrs[idx];
          exp_q.push_back(mem_word(addrs[idx]));
        end else proc_valid = 1'b0;
      end
    end
    proc_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (proc_ready) readies++;
    end
    n_total++;
    if (readies != 4 || cyc != 7 || saw_req)
      $display("FAIL b2b_ready: got %0d readies in %0d cyc req %0d want 4 in 7 req 0",
               readies, cyc, saw_req);
    else n_pass++;
    n_total++;
    if (hit_count !== 32'(exp_hits))
      $display("FAIL b2b_hits: got %0d want %0d", hit_count, exp_hits);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    seen = 1'b0;
    proc_addr = 32'h300;
    proc_valid = 1'b1;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (mem_req_valid) seen = 1'b1;
    end
    n_total++;
    if (!seen) $display("FAIL rst_fill_req: got no mem_req_valid want one");
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({mem_req_valid, proc_ready, flush_done} !== 3'b000)
      $display("FAIL rst_fill_ctl: got %b want 000",
               {mem_req_valid, proc_ready, flush_done});
    else n_pass++;
    n_total++;
    if ({hit_count, miss_count, occupancy} !== 96'd0)
      $display("FAIL rst_fill_cnt: got %0d/%0d/%0d want 0/0/0",
               hit_count, miss_count, occupancy);
    else n_pass++;
    reset = 1'b0;
    proc_valid = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    @(negedge clk);
    do_fetch(32'h100, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_evict();
    test_flush();
    test_back_to_back();
    test_reset_mid_fill();
    n_total++;
    if (miss_count !== 32'(exp_misses) || exp_q.size() != 0)
      $display("FAIL final: got miss %0d pending %0d want %0d 0",
               miss_count, exp_q.size(), exp_misses);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
